// File: rtl/gyro_spi_reader.sv
// SPI mode-3 master: configures a 3-axis gyro, then burst-reads X/Y/Z every sample
// period and presents 10-bit truncated rates with a ReadDone strobe for the FIR stage.
module gyro_spi_reader #(
    parameter int ClkDiv        = 4,
    parameter int SampleDiv     = 5000000,
    parameter int StartupCycles = 500000,
    parameter int StrobeCycles  = 16
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       Enable,
    input  logic       SpiMiso,
    output logic       SpiSclk,
    output logic       SpiMosi,
    output logic       SpiCsN,
    output logic [9:0] GyroX,
    output logic [9:0] GyroY,
    output logic [9:0] GyroZ,
    output logic       ReadDone,
    output logic       Busy
);

    localparam int DivW  = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int SmpW  = (SampleDiv > 1) ? $clog2(SampleDiv) : 1;
    localparam int WaitW = (StartupCycles > 1) ? $clog2(StartupCycles) : 1;
    localparam int StrW  = $clog2(StrobeCycles + 1);

    localparam logic [DivW-1:0]  DivLast  = DivW'(ClkDiv - 1);
    localparam logic [SmpW-1:0]  SmpLast  = SmpW'(SampleDiv - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(StartupCycles - 1);
    localparam logic [StrW-1:0]  StrLast  = StrW'(StrobeCycles);

    localparam logic [5:0]  CfgBits  = 6'd16;
    localparam logic [5:0]  ReadBits = 6'd56;
    localparam logic [55:0] CfgFrame = {8'h20, 8'h0F, 40'h0};
    localparam logic [55:0] RdFrame  = {8'hE8, 48'h0};

    typedef enum logic [2:0] {WAIT, CFG, IDLE, READ, UPDATE, STROBE} stateT;

    stateT             state;
    logic [WaitW-1:0]  waitCnt;
    logic [DivW-1:0]   divCnt;
    logic [5:0]        bitCnt;
    logic [55:0]       txShift;
    logic [47:0]       rxShift;
    logic [SmpW-1:0]   smpCnt;
    logic              timerOn;
    logic              tick;
    logic              pending;
    logic [StrW-1:0]   strCnt;
    logic [5:0]        lastBit;

    assign lastBit = (state == CFG) ? CfgBits : ReadBits;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= WAIT;
            Busy     <= 1'b1;
            waitCnt  <= '0;
            divCnt   <= '0;
            bitCnt   <= '0;
            txShift  <= '0;
            rxShift  <= '0;
            smpCnt   <= '0;
            timerOn  <= 1'b0;
            tick     <= 1'b0;
            pending  <= 1'b0;
            strCnt   <= '0;
            SpiCsN   <= 1'b1;
            SpiSclk  <= 1'b1;
            SpiMosi  <= 1'b0;
            GyroX    <= '0;
            GyroY    <= '0;
            GyroZ    <= '0;
            ReadDone <= 1'b0;
        end else begin
            // Free-running sample timer; tick is a one-cycle pulse after each wrap.
            tick <= 1'b0;
            if (timerOn) begin
                if (smpCnt == SmpLast) begin
                    smpCnt <= '0;
                    tick   <= 1'b1;
                end else begin
                    smpCnt <= smpCnt + 1'b1;
                end
            end
            if (tick && state != IDLE) pending <= 1'b1;

            case (state)
                WAIT: begin
                    if (waitCnt == WaitLast) begin
                        state   <= CFG;
                        txShift <= CfgFrame;
                        bitCnt  <= '0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end

                CFG, READ: begin
                    // First cycle in the state only drops chip select; every ClkDiv
                    // cycles after that one SCLK edge (fall: shift out, rise: sample).
                    if (SpiCsN) begin
                        SpiCsN <= 1'b0;
                        divCnt <= '0;
                    end else if (divCnt != DivLast) begin
                        divCnt <= divCnt + 1'b1;
                    end else begin
                        divCnt <= '0;
                        if (!SpiSclk) begin
                            SpiSclk <= 1'b1;
                            rxShift <= {rxShift[46:0], SpiMiso};
                            bitCnt  <= bitCnt + 1'b1;
                        end else if (bitCnt == lastBit) begin
                            SpiCsN  <= 1'b1;
                            SpiMosi <= 1'b0;
                            if (state == CFG) begin
                                state   <= IDLE;
                                Busy    <= 1'b0;
                                timerOn <= 1'b1;
                                smpCnt  <= '0;
                            end else begin
                                state <= UPDATE;
                            end
                        end else begin
                            SpiSclk <= 1'b0;
                            SpiMosi <= txShift[55];
                            txShift <= {txShift[54:0], 1'b0};
                        end
                    end
                end

                IDLE: begin
                    if (!Enable) begin
                        pending <= 1'b0;
                    end else if (tick || pending) begin
                        pending <= 1'b0;
                        state   <= READ;
                        Busy    <= 1'b1;
                        txShift <= RdFrame;
                        bitCnt  <= '0;
                    end
                end

                UPDATE: begin
                    // rxShift holds XL XH YL YH ZL ZH; keep bits [15:6] of each {H,L}.
                    GyroX  <= {rxShift[39:32], rxShift[47:46]};
                    GyroY  <= {rxShift[23:16], rxShift[31:30]};
                    GyroZ  <= {rxShift[7:0],   rxShift[15:14]};
                    strCnt <= '0;
                    state  <= STROBE;
                end

                STROBE: begin
                    if (strCnt == StrLast) begin
                        ReadDone <= 1'b0;
                        state    <= IDLE;
                        Busy     <= 1'b0;
                    end else begin
                        if (strCnt == '0) ReadDone <= 1'b1;
                        strCnt <= strCnt + 1'b1;
                    end
                end

                default: state <= WAIT;
            endcase
        end
    end

endmodule
